// File: rtl/serial_link_pkg.sv
// Shared types and constants for the PRBS serial link frame sequencer.
// The CRC helper is only referenced when LINK_CRC_EN is defined.
package serial_link_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CRC} link_state_e;

    localparam logic [31:0] DEF_SYNC_WORD = 32'hA5A5_F00F;
    localparam logic [31:0] DEF_IDLE_WORD = 32'h0000_0000;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

    // Word-parallel CRC-32 step over the low nbits of data, MSB first, non-reflected.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                               input logic [63:0] data,
                                               input int unsigned nbits);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 63; i >= 0; i--) begin
            if (i < int'(nbits)) begin
                fb = c[31] ^ data[i];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ CRC32_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/link_word_timer.sv
// Free-running bit counter; flags the last bit of every serializer word
// so the controller can act on word boundaries without a divided clock.
module link_word_timer #(
    parameter int SER_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    output logic boundary_o
);

    localparam int CW = $clog2(SER_WIDTH);

    logic [CW-1:0] bit_cnt_q;

    // Power-of-two width, so the natural wrap gives 0..SER_WIDTH-1.
    always_ff @(posedge clk) begin
        if (!rst_n) bit_cnt_q <= '0;
        else        bit_cnt_q <= bit_cnt_q + 1'b1;
    end

    assign boundary_o = (bit_cnt_q == CW'(SER_WIDTH - 1));

endmodule

// File: rtl/serial_link_ctrl.sv
// Frame sequencer: idle / sync header / PRBS payload words, one per boundary.
// Define LINK_CRC_EN to append a CRC-32 word after the payload.
module serial_link_ctrl
    import serial_link_pkg::*;
#(
    parameter int                   SER_WIDTH     = 32,
    parameter logic [SER_WIDTH-1:0] SYNC_WORD     = SER_WIDTH'(DEF_SYNC_WORD),
    parameter logic [SER_WIDTH-1:0] IDLE_WORD     = SER_WIDTH'(DEF_IDLE_WORD),
    parameter int                   SYNC_WORDS    = 2,
    parameter int                   PAYLOAD_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [SER_WIDTH-1:0] prbs_word,
    output logic                 prbs_adv,
    output logic                 ser_load,
    output logic [SER_WIDTH-1:0] ser_word,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frame_cnt
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_WORDS - 1);
    localparam logic [7:0] PAY_LAST  = 8'(PAYLOAD_WORDS - 1);

    link_state_e state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        start_pend_q, start_pend_d;
    logic        stop_pend_q, stop_pend_d;
    logic        done_q, done_d;
    logic        busy_q;
    logic        boundary, start_req, stop_req, frame_end;
`ifdef LINK_CRC_EN
    logic [31:0] crc_q, crc_d;
`endif

    link_word_timer #(.SER_WIDTH(SER_WIDTH)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .boundary_o (boundary)
    );

    assign start_req = start_pend_q | start;
    assign stop_req  = stop_pend_q | stop;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        frame_cnt_d  = frame_cnt_q;
        done_d       = 1'b0;
        start_pend_d = start_req;
        stop_pend_d  = stop_req;
        frame_end    = 1'b0;
`ifdef LINK_CRC_EN
        crc_d        = crc_q;
`endif
        if (boundary) begin
            start_pend_d = 1'b0;
            stop_pend_d  = 1'b0;
            case (state_q)
                IDLE: if (start_req && !stop_req) begin
                    state_d = SYNC;
                    wcnt_d  = '0;
                end
                SYNC: if (wcnt_q == SYNC_LAST) begin
                    state_d = PAYLOAD;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
                PAYLOAD: begin
`ifdef LINK_CRC_EN
                    crc_d = crc32_word(crc_q, 64'(prbs_word), SER_WIDTH);
`endif
                    if (wcnt_q == PAY_LAST) begin
`ifdef LINK_CRC_EN
                        state_d = CRC;
                        wcnt_d  = '0;
`else
                        frame_end = 1'b1;
`endif
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
`ifdef LINK_CRC_EN
                CRC: frame_end = 1'b1;
`endif
                default: state_d = IDLE;
            endcase
            if (frame_end) begin
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = continuous ? SYNC : IDLE;
                wcnt_d      = '0;
            end
            // Abort wins over completion; the word on the wire this boundary still goes out.
            if (stop_req && state_q != IDLE) begin
                state_d     = IDLE;
                wcnt_d      = '0;
                done_d      = 1'b0;
                frame_cnt_d = frame_cnt_q;
            end
`ifdef LINK_CRC_EN
            if (state_d == SYNC && state_q != SYNC) crc_d = CRC32_INIT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            frame_cnt_q  <= '0;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            frame_cnt_q  <= frame_cnt_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            done_q       <= done_d;
            busy_q       <= (state_d != IDLE);
        end
    end

`ifdef LINK_CRC_EN
    always_ff @(posedge clk) begin
        if (!rst_n) crc_q <= CRC32_INIT;
        else        crc_q <= crc_d;
    end
`endif

    always_comb begin
        ser_word = IDLE_WORD;
        case (state_q)
            SYNC:    ser_word = SYNC_WORD;
            PAYLOAD: ser_word = prbs_word;
`ifdef LINK_CRC_EN
            CRC:     ser_word = SER_WIDTH'(crc_q);
`endif
            default: ser_word = IDLE_WORD;
        endcase
    end

    assign ser_load  = boundary;
    assign prbs_adv  = boundary && (state_q == PAYLOAD);
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_link_ctrl.sv
// Directed word-level vectors for serial_link_ctrl (default parameters, CRC disabled).
module tb_serial_link_ctrl;

    localparam int IDL = 0, SYN = 1, PAY = 2;

    typedef struct {
        bit start, stop, cont;
        int kind;
        bit busy, done;
        int fcnt;
        int pre;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, continuous;
    logic [31:0] prbs_word;
    logic        prbs_adv, ser_load, busy, done;
    logic [31:0] ser_word;
    logic [15:0] frame_cnt;
    logic [15:0] adv_n = '0;

    int   nvec = 0, nerr = 0, cyc = 0, strobe_err = 0, exp_pay_n = 0;
    vec_t tab[$];

    serial_link_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .prbs_word(prbs_word), .prbs_adv(prbs_adv), .ser_load(ser_load),
        .ser_word(ser_word), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // PRBS generator stand-in: steps a tagged counter on each advance request.
    always @(posedge clk) if (prbs_adv) adv_n <= adv_n + 16'd1;
    assign prbs_word = {16'hC0DE, adv_n};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ser_load !== ((cyc % 32) == 31)) strobe_err++;
        if ((cyc % 32) != 31 && prbs_adv !== 1'b0) strobe_err++;
        if ((cyc % 32) != 0 && done !== 1'b0) strobe_err++;
    endtask

    function automatic void add(bit s, bit p, bit c, int k, bit b, bit d, int f, int pre = 0);
        vec_t v;
        v.start = s; v.stop = p; v.cont = c; v.kind = k;
        v.busy = b; v.done = d; v.fcnt = f; v.pre = pre;
        tab.push_back(v);
    endfunction

    function automatic logic [31:0] exp_word(int k);
        logic [15:0] n;
        n = 16'(exp_pay_n);
        case (k)
            SYN:     return 32'hA5A5_F00F;
            PAY:     return {16'hC0DE, n};
            default: return 32'h0000_0000;
        endcase
    endfunction

    initial begin
        // idle after reset
        repeat (3) add(0, 0, 0, IDL, 0, 0, 0);
        // single frame from a mid-word start pulse
        add(0, 0, 0, IDL, 0, 0, 0, 1);
        repeat (2) add(0, 0, 0, SYN, 1, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 0, 0, PAY, 1, i == 16, (i == 16) ? 1 : 0);
        add(0, 0, 0, IDL, 0, 0, 1);
        // three back-to-back continuous frames, start held
        add(1, 0, 1, IDL, 0, 0, 1);
        for (int f = 1; f <= 3; f++) begin
            repeat (2) add(1, 0, 1, SYN, 1, 0, f);
            for (int i = 1; i <= 16; i++)
                add(1, 0, (i < 16 || f < 3), PAY, 1, i == 16, (i == 16) ? f + 1 : f);
        end
        add(0, 0, 0, IDL, 0, 0, 4);
        // abort on the sixth payload word
        add(1, 0, 0, IDL, 0, 0, 4);
        repeat (2) add(0, 0, 0, SYN, 1, 0, 4);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, PAY, 1, 0, 4);
        add(0, 1, 0, PAY, 1, 0, 4);
        repeat (2) add(0, 0, 0, IDL, 0, 0, 4);
        // start+stop together: pending (mid-word) and at the boundary itself
        add(0, 0, 0, IDL, 0, 0, 4, 2);
        add(0, 0, 0, IDL, 0, 0, 4);
        add(1, 1, 0, IDL, 0, 0, 4);
        add(0, 0, 0, IDL, 0, 0, 4);
        // frame that will be cut by reset
        add(1, 0, 0, IDL, 0, 0, 4);
        repeat (2) add(0, 0, 0, SYN, 1, 0, 4);
        add(0, 0, 0, PAY, 1, 0, 4);

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load", ser_load, 0);
        chk("rst_adv", prbs_adv, 0);
        chk("rst_word", ser_word, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fcnt", frame_cnt, 0);
        rst_n = 1'b1;
        cyc = 0;

        foreach (tab[i]) begin
            if (tab[i].pre != 0) begin
                while ((cyc % 32) != 10) tick();
                start = 1'b1;
                stop  = (tab[i].pre == 2);
                tick();
                start = 1'b0;
                stop  = 1'b0;
                chk("busy_after_pulse", busy, 0);
            end
            while ((cyc % 32) != 31) tick();
            start      = tab[i].start;
            stop       = tab[i].stop;
            continuous = tab[i].cont;
            chk("load", ser_load, 1);
            chk("word", ser_word, exp_word(tab[i].kind));
            chk("adv", prbs_adv, tab[i].kind == PAY);
            chk("busy", busy, tab[i].busy);
            if (tab[i].kind == PAY) exp_pay_n++;
            tick();
            start = 1'b0;
            stop  = 1'b0;
            chk("done", done, tab[i].done);
            chk("fcnt", frame_cnt, 64'(tab[i].fcnt));
            chk("strobe_quiet", 64'(strobe_err), 0);
            strobe_err = 0;
        end
        chk("adv_total", adv_n, 71);

        // reset in the middle of the payload
        repeat (3) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_word", ser_word, 32'h0);
        chk("midrst_fcnt", frame_cnt, 0);
        chk("midrst_load", ser_load, 0);
        chk("midrst_adv", prbs_adv, 0);
        rst_n = 1'b1;
        cyc = 0;
        strobe_err = 0;
        while (cyc < 31) tick();
        chk("first_load_after_rst", ser_load, 1);
        chk("post_rst_word", ser_word, 32'h0);
        chk("post_rst_quiet", 64'(strobe_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
